pdetect_stream_mon_multi: RTL and testbench
===========================================

# pdetect_stream_mon_multi

Parametrised successor to the single-pattern stream monitor. Sits inline on a valid/ready byte-or-word stream, forwards every beat through a one-stage register slice, and simultaneously matches a sliding window of the last PAT_LEN accepted beats against NUM_PAT masked patterns. It reports per-pattern detect flags, a one-cycle hit strobe and saturating per-pattern match counters.

## Interface
- DATA_W, 8, beat width in bits
- PAT_LEN, 4, beats per pattern (≥1)
- NUM_PAT, 2, number of independent patterns (≥1)
- PATTERNS, 0, NUM_PAT*PAT_LEN*DATA_W bits; pattern p in bits [(p+1)*PAT_LEN*DATA_W-1 : p*PAT_LEN*DATA_W]; first-arriving beat in the most-significant DATA_W of that slice
- MASKS, all ones, same layout as PATTERNS; bit=1 compares, bit=0 is don't-care
- CNT_W, 16, width of each match counter
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_m_data  in  DATA_W  upstream beat
- i_m_valid  in  1  upstream valid
- o_m_ready  out  1  upstream ready
- o_s_data  out  DATA_W  downstream beat
- o_s_valid  out  1  downstream valid
- i_s_ready  in  1  downstream ready
- i_clear  in  1  synchronous clear of history, flags and counters
- o_detected  out  NUM_PAT  per-pattern match flag for the beat most recently accepted
- o_hit  out  1  one-cycle strobe: any pattern matched on the last accept
- o_match_cnt  out  NUM_PAT*CNT_W  per-pattern saturating counts, pattern p in bits [(p+1)*CNT_W-1 : p*CNT_W]

## Operation
- Accept = i_m_valid & o_m_ready. o_m_ready = i_rst_n & (~o_s_valid | i_s_ready).
- Register slice: on accept, o_s_data<=i_m_data, o_s_valid<=1; else if i_s_ready, o_s_valid<=0. No beat dropped, duplicated or reordered.
- History: PAT_LEN-deep shift register of accepted beats plus fill counter 0..PAT_LEN (saturates). Window valid when fill, including the new beat, reaches PAT_LEN.
- Per pattern: match = window valid & (((window ^ pattern) & mask) == 0), evaluated on the window including the beat being accepted.
- On accept: o_detected[p]<=match[p]; o_hit<=|match; each matching counter increments, saturating at 2^CNT_W-1.
- Without accept: o_detected holds (stalls never deassert it); o_hit<=0.
- Overlapping matches count separately (PAT_LEN=4, pattern AAAAAAAA, five 0xAA beats -> count 2).
- i_clear: fill<=0, o_detected<=0, o_hit<=0, counters<=0. Clear and accept in the same cycle: clear wins for history/flags/counters; the beat still passes the data path.
- Reset values: o_s_valid 0, o_s_data 0, o_detected 0, o_hit 0, o_match_cnt 0, fill 0, o_m_ready 0 while i_rst_n low.

## Timing
- Data latency 1 cycle: beat accepted at edge k is on o_s_data after edge k.
- o_detected/o_hit/o_match_cnt update at the same edge k, so o_detected qualifies the beat currently on o_s_data.
- Full throughput: one beat per cycle when i_s_ready stays high.
- Reset deassertion mid-stream: all state restarts empty; first match possible on the PAT_LEN-th accept after reset.

## Configuration
- PDETECT_FRAME_EN defined: adds i_m_last (in, 1) and o_s_last (out, 1), registered alongside data; fill resets to 0 after an accepted beat with i_m_last=1, so patterns never span frames (the last beat itself may complete a match).
- Not defined: no last ports; history is continuous across all beats.

## Structure
- Package pdetect_pkg: clog2-based fill-counter width helper, pattern/mask slice extraction functions, saturating-increment function.
- Sub-module pdetect_matcher (one per pattern via generate): takes window, pattern, mask, window-valid, accept, clear; owns its detect flag and counter.

## Test plan
- DATA_W=8, PAT_LEN=4, NUM_PAT=2, P0=0A0B0C0D mask FFFFFFFF, P1=0A000C00 mask FF00FF00.
- Send 0A,0B,0C,0D then idle 3 cycles -> o_detected=2'b11, o_hit one cycle, counts 1/1, o_detected held through idle.
- Send 0A,FF,0C,EE -> o_detected=2'b10, P1 count increments, P0 unchanged; then 0F,0F,0F,0F -> o_detected=2'b00.
- Random i_s_ready backpressure over 1000 beats -> o_s_data sequence identical to input, o_m_ready low only when o_s_valid & ~i_s_ready.
- Assert i_clear on the cycle 0D is accepted -> no detect, counts 0, 0D still appears on o_s_data.
- CNT_W=2, repeat P0 five times -> P0 count saturates at 3; with PDETECT_FRAME_EN, 0A,0B(last),0C,0D -> no detect.

Source files
------------

// File: rtl/pdetect_pkg.sv
// Shared helpers for the multi-pattern stream monitor: fill-counter sizing,
// flat-vector slice indexing and a saturating increment.
package pdetect_pkg;

  // Bits needed to hold a fill count of 0..pat_len inclusive.
  function automatic int fill_w(input int pat_len);
    return (pat_len < 1) ? 1 : $clog2(pat_len + 1);
  endfunction

  // Low bit of slice idx in a flat vector of slice_w-wide slices.
  function automatic int slice_lo(input int idx, input int slice_w);
    return idx * slice_w;
  endfunction

  // High bit of slice idx in a flat vector of slice_w-wide slices.
  function automatic int slice_hi(input int idx, input int slice_w);
    return (idx + 1) * slice_w - 1;
  endfunction

  // Increment that sticks at 2^width-1 instead of wrapping (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (val >= max_v) ? max_v : val + 64'd1;
  endfunction

endpackage

// File: rtl/pdetect_matcher.sv
// One masked-pattern comparator: combinational match on the current window,
// plus the registered detect flag and saturating match counter it owns.
module pdetect_matcher
  import pdetect_pkg::*;
#(
  parameter int WIN_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIN_W-1:0] i_window,
  input  logic [WIN_W-1:0] i_pattern,
  input  logic [WIN_W-1:0] i_mask,
  input  logic             i_win_valid,
  input  logic             i_accept,
  input  logic             i_clear,
  output logic             o_match,
  output logic             o_detected,
  output logic [CNT_W-1:0] o_cnt
);

  logic             det_d, det_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign o_match = i_win_valid & (((i_window ^ i_pattern) & i_mask) == '0);

  // Flag follows the latest accepted beat; counter bumps on each matching accept.
  always_comb begin
    det_d = det_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      det_d = 1'b0;
      cnt_d = '0;
    end else if (i_accept) begin
      det_d = o_match;
      if (o_match) cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      det_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      det_q <= det_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_detected = det_q;
  assign o_cnt      = cnt_q;

endmodule

// File: rtl/pdetect_stream_mon_multi.sv
// Inline valid/ready register slice that also matches the last PAT_LEN
// accepted beats against NUM_PAT masked patterns.
// Optional feature: define PDETECT_FRAME_EN to add i_m_last/o_s_last and
// restart the history after every frame-ending beat.
module pdetect_stream_mon_multi
  import pdetect_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int NUM_PAT = 2,
  parameter logic [NUM_PAT*PAT_LEN*DATA_W-1:0] PATTERNS = '0,
  parameter logic [NUM_PAT*PAT_LEN*DATA_W-1:0] MASKS    = '1,
  parameter int CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DATA_W-1:0]        i_m_data,
  input  logic                     i_m_valid,
  output logic                     o_m_ready,
`ifdef PDETECT_FRAME_EN
  input  logic                     i_m_last,
  output logic                     o_s_last,
`endif
  output logic [DATA_W-1:0]        o_s_data,
  output logic                     o_s_valid,
  input  logic                     i_s_ready,
  input  logic                     i_clear,
  output logic [NUM_PAT-1:0]       o_detected,
  output logic                     o_hit,
  output logic [NUM_PAT*CNT_W-1:0] o_match_cnt
);

  localparam int WIN_W = PAT_LEN * DATA_W;
  localparam int FW    = fill_w(PAT_LEN);

  logic              accept;
  logic              win_valid;
  logic [WIN_W-1:0]  window;
  logic [NUM_PAT-1:0] match;

  logic [DATA_W-1:0] s_data_d, s_data_q;
  logic              s_valid_d, s_valid_q;
  logic [WIN_W-1:0]  hist_d, hist_q;
  logic [FW-1:0]     fill_d, fill_q;
  logic              hit_d, hit_q;
`ifdef PDETECT_FRAME_EN
  logic              s_last_d, s_last_q;
`endif

  // Handshake, window assembly (oldest beat in the MSBs) and fill tracking.
  always_comb begin
    o_m_ready = i_rst_n & (~s_valid_q | i_s_ready);
    accept    = i_m_valid & o_m_ready;
    window    = (hist_q << DATA_W) | WIN_W'(i_m_data);
    win_valid = (int'(fill_q) >= PAT_LEN - 1);

    s_data_d  = s_data_q;
    s_valid_d = s_valid_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    hit_d     = 1'b0;
`ifdef PDETECT_FRAME_EN
    s_last_d  = s_last_q;
`endif

    // Data path ignores i_clear so a cleared beat is still forwarded.
    if (accept) begin
      s_data_d  = i_m_data;
      s_valid_d = 1'b1;
`ifdef PDETECT_FRAME_EN
      s_last_d  = i_m_last;
`endif
    end else if (i_s_ready) begin
      s_valid_d = 1'b0;
    end

    if (i_clear) begin
      fill_d = '0;
    end else if (accept) begin
      hist_d = window;
      hit_d  = |match;
      fill_d = (int'(fill_q) >= PAT_LEN) ? fill_q : fill_q + FW'(1);
`ifdef PDETECT_FRAME_EN
      if (i_m_last) fill_d = '0;
`endif
    end
  end

  // Slice, history and strobe registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_data_q  <= '0;
      s_valid_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      hit_q     <= 1'b0;
`ifdef PDETECT_FRAME_EN
      s_last_q  <= 1'b0;
`endif
    end else begin
      s_data_q  <= s_data_d;
      s_valid_q <= s_valid_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
`ifdef PDETECT_FRAME_EN
      s_last_q  <= s_last_d;
`endif
    end
  end

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
    localparam int PLO = slice_lo(p, WIN_W);
    localparam int CLO = slice_lo(p, CNT_W);
    logic [CNT_W-1:0] cnt;

    pdetect_matcher #(
      .WIN_W (WIN_W),
      .CNT_W (CNT_W)
    ) u_matcher (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_window    (window),
      .i_pattern   (PATTERNS[PLO +: WIN_W]),
      .i_mask      (MASKS[PLO +: WIN_W]),
      .i_win_valid (win_valid),
      .i_accept    (accept),
      .i_clear     (i_clear),
      .o_match     (match[p]),
      .o_detected  (o_detected[p]),
      .o_cnt       (cnt)
    );

    assign o_match_cnt[CLO +: CNT_W] = cnt;
  end

  assign o_s_data  = s_data_q;
  assign o_s_valid = s_valid_q;
  assign o_hit     = hit_q;
`ifdef PDETECT_FRAME_EN
  assign o_s_last  = s_last_q;
`endif

endmodule

// File: tb/tb_pdetect_stream_mon_multi.sv
// Bench for pdetect_stream_mon_multi (default build): directed pattern steps,
// clear/reset cases, counter saturation and a randomized backpressure run,
// all checked against a beat-list reference model.
module tb_pdetect_stream_mon_multi;

  localparam int DATA_W  = 8;
  localparam int PAT_LEN = 4;
  localparam int NUM_PAT = 2;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [DATA_W-1:0]        m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic                     clear;
  logic [NUM_PAT-1:0]       detected;
  logic                     hit;
  logic [NUM_PAT*CNT_W-1:0] match_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: patterns per beat (first-arriving first).
  logic [7:0] pat [NUM_PAT][PAT_LEN];
  logic [7:0] msk [NUM_PAT][PAT_LEN];
  logic [7:0] hist [$];
  logic [7:0] outq [$];
  int         mcnt [NUM_PAT];
  logic [NUM_PAT-1:0] mdet;
  logic       mhit;

  pdetect_stream_mon_multi #(
    .DATA_W   (DATA_W),
    .PAT_LEN  (PAT_LEN),
    .NUM_PAT  (NUM_PAT),
    .PATTERNS (64'h0A000C00_0A0B0C0D),
    .MASKS    (64'hFF00FF00_FFFFFFFF),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_m_data    (m_data),
    .i_m_valid   (m_valid),
    .o_m_ready   (m_ready),
    .o_s_data    (s_data),
    .o_s_valid   (s_valid),
    .i_s_ready   (s_ready),
    .i_clear     (clear),
    .o_detected  (detected),
    .o_hit       (hit),
    .o_match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    outq.delete();
    mdet = '0;
    mhit = 1'b0;
    for (int p = 0; p < NUM_PAT; p++) mcnt[p] = 0;
  endtask

  task automatic check_model();
    chk("detected", detected, mdet);
    chk("hit", hit, mhit);
    for (int p = 0; p < NUM_PAT; p++)
      chk($sformatf("cnt%0d", p), match_cnt[p*CNT_W +: CNT_W], mcnt[p]);
  endtask

  // Apply one cycle of inputs, check handshake/order, then model and outputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic sr,
                       input logic clr, output logic acc);
    logic       pop;
    logic       ok;
    logic [7:0] front;
    m_valid = v; m_data = d; s_ready = sr; clear = clr;
    @(negedge clk);
    chk("m_ready", m_ready, !(s_valid && !sr));
    acc = v & m_ready;
    pop = s_valid & sr;
    if (pop) begin
      chk("beat_pending", outq.size() > 0, 1);
      if (outq.size() > 0) begin
        front = outq.pop_front();
        chk("s_data_order", s_data, front);
      end
    end
    @(posedge clk);
    #1;
    if (acc) outq.push_back(d);
    if (clr) begin
      hist.delete();
      mdet = '0;
      mhit = 1'b0;
      for (int p = 0; p < NUM_PAT; p++) mcnt[p] = 0;
    end else if (acc) begin
      hist.push_back(d);
      if (hist.size() > PAT_LEN) void'(hist.pop_front());
      for (int p = 0; p < NUM_PAT; p++) begin
        ok = (hist.size() == PAT_LEN);
        for (int i = 0; i < PAT_LEN && ok; i++)
          if (((hist[i] ^ pat[p][i]) & msk[p][i]) != 8'h00) ok = 1'b0;
        mdet[p] = ok;
        if (ok && mcnt[p] < CNT_MAX) mcnt[p]++;
      end
      mhit = |mdet;
    end else begin
      mhit = 1'b0;
    end
    if (acc) begin
      chk("s_valid_after_accept", s_valid, 1);
      chk("s_data_latency", s_data, d);
    end
    check_model();
  endtask

  task automatic send(input logic [7:0] d);
    logic acc;
    cycle(1'b1, d, 1'b1, 1'b0, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_valid = 1'b0; m_data = '0; s_ready = 1'b1; clear = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_m_ready", m_ready, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_detected", detected, 0);
    chk("rst_hit", hit, 0);
    chk("rst_cnt", match_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       acc;
    logic [7:0] d;
    int         k;

    pat[0] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    msk[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pat[1] = '{8'h0A, 8'h00, 8'h0C, 8'h00};
    msk[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00};

    do_reset();

    // Both patterns match; flag held over idle, hit one cycle.
    send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    chk("abcd_detected", detected, 2'b11);
    chk("abcd_hit", hit, 1);
    chk("abcd_cnt", match_cnt, {2'd1, 2'd1});
    idle(3);
    chk("abcd_held", detected, 2'b11);
    chk("abcd_hit_clear", hit, 0);

    // Only the masked pattern matches.
    send(8'h0A); send(8'hFF); send(8'h0C); send(8'hEE);
    chk("masked_detected", detected, 2'b10);
    chk("masked_cnt", match_cnt, {2'd2, 2'd1});
    send(8'h0F); send(8'h0F); send(8'h0F); send(8'h0F);
    chk("nomatch_detected", detected, 2'b00);

    // Clear on the completing beat suppresses detection but forwards the beat.
    send(8'h0A); send(8'h0B); send(8'h0C);
    cycle(1'b1, 8'h0D, 1'b1, 1'b1, acc);
    chk("clear_detected", detected, 2'b00);
    chk("clear_cnt", match_cnt, 0);
    chk("clear_data", s_data, 8'h0D);
    idle(1);

    // Saturation: five pattern repeats stick at the counter maximum.
    for (int r = 0; r < 5; r++) begin
      send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    end
    chk("sat_cnt", match_cnt, {2'd3, 2'd3});

    // Window restarts after reset: needs PAT_LEN fresh beats to match.
    send(8'h0A); send(8'h0B);
    do_reset();
    send(8'h0C); send(8'h0D);
    chk("post_reset_nomatch", detected, 2'b00);
    send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    chk("post_reset_match", detected, 2'b11);

    // Randomized backpressure and valid gaps, biased toward pattern beats.
    k = 0;
    for (int n = 0; n < 1000; ) begin
      d = ($urandom_range(0, 9) < 7) ? pat[0][k % PAT_LEN] : 8'($urandom);
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0, acc);
      if (acc) begin
        n++;
        k++;
      end
    end

    // Drain the slice and confirm every accepted beat came out.
    idle(2);
    chk("drained", outq.size(), 0);
    chk("drained_valid", s_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
